// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared types, defaults and width helper for the round-robin counter scheduler
package ctr_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
    localparam int CTR_MOD = 3;
    localparam int CTR_NWRAP = 2;
    function automatic int cw(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ctr_rr_sched_if.sv
// ctr_rr_sched_if: request/grant/counter bundle between requesters (master) and scheduler (slave)
interface ctr_rr_sched_if
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MOD = CTR_MOD
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [cw(MOD)-1:0] cnt_out;
    logic busy;
    modport master(output req, input grant, done, cnt_out, busy);
    modport slave(input req, output grant, done, cnt_out, busy);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, lowest set req at or after ptr wins (wrapping)
module rr_pick
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [cw(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]    win,
    output logic               vld
);
    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] lsb;
    // low half holds only requests at/after ptr, high half all of them as the wrap-around fallback
    assign dbl = {req, req & ({NREQ{1'b1}} << ptr)};
    assign lsb = dbl & (-dbl);
    assign win = lsb[NREQ-1:0] | lsb[2*NREQ-1:NREQ];
    assign vld = |req;
endmodule

// File: rtl/ctr_rr_sched.sv
// ctr_rr_sched: grants a shared mod-MOD counter to one requester at a time for NWRAP full cycles
module ctr_rr_sched
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MOD = CTR_MOD,
    parameter int NWRAP = CTR_NWRAP
) (
    input logic clk,
    input logic rst_n,
    ctr_rr_sched_if.slave bus
);
    localparam int CW = cw(MOD);
    localparam int PW = cw(NREQ);
    localparam int WW = cw(NWRAP + 1);
    state_t state;
    logic [NREQ-1:0] gnt, dn, win;
    logic [PW-1:0] ptr, own, win_idx, nxt;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wrap;
    logic bsy, vld, top, last;
    rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req), .ptr(ptr), .win(win), .vld(vld));
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (win[i]) win_idx = PW'(i);
    end
    assign top = cnt == CW'(MOD - 1);
    assign last = top && wrap == WW'(NWRAP - 1);
    assign nxt = own == PW'(NREQ - 1) ? '0 : own + PW'(1);
    assign bus.grant = gnt;
    assign bus.done = dn;
    assign bus.cnt_out = cnt;
    assign bus.busy = bsy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt <= '0;
            dn <= '0;
            own <= '0;
            ptr <= '0;
            cnt <= '0;
            wrap <= '0;
            bsy <= 1'b0;
        end else begin
            dn <= '0;
            if (state != RUN) begin
                gnt <= vld ? win : '0;
                own <= win_idx;
                cnt <= '0;
                wrap <= '0;
                bsy <= vld;
                state <= vld ? RUN : IDLE;
            end else if (!bus.req[own] || last) begin
                // a dropped request ends the grant early and forfeits the done pulse
                gnt <= '0;
                dn <= bus.req[own] ? gnt : '0;
                cnt <= '0;
                wrap <= '0;
                bsy <= 1'b0;
                ptr <= nxt;
                state <= RELEASE;
            end else begin
                cnt <= top ? '0 : cnt + CW'(1);
                wrap <= wrap + WW'(top);
            end
        end
    end
endmodule

// File: tb/tb_ctr_rr_sched.sv
// tb_ctr_rr_sched: scoreboard bench for default and MOD=4/NWRAP=1/NREQ=3 schedulers
module tb_ctr_rr_sched;
    typedef struct {
        int g;
        int c;
        int d;
        int b;
        int dl;
    } evt_t;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
    int gapa = 0;
    int gapb = 0;
    evt_t qa[$];
    evt_t qb[$];
    ctr_rr_sched_if #(.NREQ(4), .MOD(3)) ifa ();
    ctr_rr_sched_if #(.NREQ(3), .MOD(4)) ifb ();
    ctr_rr_sched #(.NREQ(4), .MOD(3), .NWRAP(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    ctr_rr_sched #(.NREQ(3), .MOD(4), .NWRAP(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit sel, input int g, input int c, input int d, input int b, input int dl);
        evt_t e;
        e = '{g, c, d, b, dl};
        if (sel) qb.push_back(e);
        else qa.push_back(e);
    endtask

    // one full grant to idx: every run cycle, then the done cycle; dl0=0 leaves the leading gap unchecked
    task automatic exp_grant(input bit sel, input int idx, input int dl0);
        int m;
        int nw;
        m = sel ? 4 : 3;
        nw = sel ? 1 : 2;
        for (int k = 0; k < m * nw; k++) push(sel, 1 << idx, k % m, 0, 1, k == 0 ? dl0 : 1);
        push(sel, 0, 0, 1 << idx, 0, 1);
    endtask

    task automatic mon(input bit sel, input int g, input int c, input int d, input int b, input int gap);
        evt_t e;
        total++;
        if ((sel ? qb.size() : qa.size()) == 0) begin
            bad++;
            $display("FAIL mon_%0d unexpected grant=%0h cnt=%0d done=%0h busy=%0d", sel, g, c, d, b);
        end else begin
            e = sel ? qb.pop_front() : qa.pop_front();
            if (e.g != g || e.c != c || e.d != d || e.b != b || (e.dl != 0 && e.dl != gap)) begin
                bad++;
                $display("FAIL mon_%0d got grant=%0h cnt=%0d done=%0h busy=%0d gap=%0d want grant=%0h cnt=%0d done=%0h busy=%0d gap=%0d",
                         sel, g, c, d, b, gap, e.g, e.c, e.d, e.b, e.dl);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) gapa = 0;
        else begin
            gapa++;
            if (ifa.grant != 0 || ifa.done != 0) begin
                mon(1'b0, int'(ifa.grant), int'(ifa.cnt_out), int'(ifa.done), int'(ifa.busy), gapa);
                gapa = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) gapb = 0;
        else begin
            gapb++;
            if (ifb.grant != 0 || ifb.done != 0) begin
                mon(1'b1, int'(ifb.grant), int'(ifb.cnt_out), int'(ifb.done), int'(ifb.busy), gapb);
                gapb = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ifa.req = '0;
        ifb.req = '0;
        tick(2);
        chk("rst_grant", int'(ifa.grant), 0);
        chk("rst_cnt", int'(ifa.cnt_out), 0);
        chk("rst_done", int'(ifa.done), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_b", int'({ifb.grant, ifb.cnt_out, ifb.done, ifb.busy}), 0);
        rst_n = 1'b1;
        tick(2);
        // single requester served twice back-to-back
        exp_grant(1'b0, 2, 0);
        exp_grant(1'b0, 2, 1);
        ifa.req = 4'b0100;
        tick(14);
        ifa.req = '0;
        tick(3);
        // reset mid-grant (pointer at 3, so index 3 holds)
        push(1'b0, 8, 0, 0, 1, 0);
        push(1'b0, 8, 1, 0, 1, 1);
        ifa.req = 4'b1111;
        tick(2);
        #5;
        chk("pre_rst_busy", int'(ifa.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", int'(ifa.grant), 0);
        chk("mid_rst_cnt", int'(ifa.cnt_out), 0);
        chk("mid_rst_done", int'(ifa.done), 0);
        chk("mid_rst_busy", int'(ifa.busy), 0);
        tick(2);
        // round robin from a fresh pointer
        for (int r = 0; r < 2; r++) begin
            exp_grant(1'b0, 0, r == 0 ? 0 : 1);
            exp_grant(1'b0, 1, 1);
            exp_grant(1'b0, 3, 1);
        end
        ifa.req = 4'b1011;
        rst_n = 1'b1;
        tick(42);
        ifa.req = '0;
        tick(3);
        // abort of index 1 at cnt=1, index 2 takes over after the gap
        push(1'b0, 2, 0, 0, 1, 0);
        push(1'b0, 2, 1, 0, 1, 1);
        exp_grant(1'b0, 2, 2);
        ifa.req = 4'b0110;
        tick(2);
        ifa.req = 4'b0100;
        tick(8);
        ifa.req = '0;
        tick(3);
        // index 0 arriving mid-grant must not pre-empt index 3
        exp_grant(1'b0, 3, 0);
        exp_grant(1'b0, 0, 1);
        ifa.req = 4'b1000;
        tick(2);
        ifa.req = 4'b1001;
        tick(12);
        ifa.req = '0;
        tick(3);
        // alternate parameters: pointer wraps 2 -> 0
        exp_grant(1'b1, 0, 0);
        exp_grant(1'b1, 1, 1);
        exp_grant(1'b1, 2, 1);
        exp_grant(1'b1, 0, 1);
        ifb.req = 3'b111;
        tick(20);
        ifb.req = '0;
        tick(3);
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
